// File: rtl/controller_sequencer.sv
// rtl/controller_sequencer.sv - T1..T6 ring-counter control sequencer for an 8-bit accumulator machine
//
// Optional feature: define CTRL_JMP_EN to add the pc_load port and the JMP (0011) opcode.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   ena               step enable; low freezes the ring and gates every control off
//   instr[7:0]        instruction register contents, opcode in [7:4]
//   pc_out, pc_inc    program counter bus drive / increment
//   pc_load           program counter load from bus (CTRL_JMP_EN only)
//   mar_load          memory address register load
//   ram_out           RAM bus drive
//   ir_load, ir_out   instruction register load / operand nibble bus drive
//   a_load, a_out     accumulator load / bus drive
//   b_load            B register load
//   alu_sub, alu_out  ALU subtract select / bus drive
//   out_load          output register load
//   tstate[5:0]       one-hot T-state, bit0 = T1
//   halted            high after HLT until reset

module controller_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] instr,
  output logic       pc_out,
  output logic       pc_inc,
`ifdef CTRL_JMP_EN
  output logic       pc_load,
`endif
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_sub,
  output logic       alu_out,
  output logic       out_load,
  output logic [5:0] tstate,
  output logic       halted
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
`ifdef CTRL_JMP_EN
  localparam logic [3:0] OP_JMP = 4'h3;
`endif
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  t_state_e   state_q, state_d;
  logic       halted_q, halted_d;
  logic [3:0] opcode;
  logic       active;
  logic       unused_operand;

  assign opcode         = instr[7:4];
  assign unused_operand = ^instr[3:0];
  assign active         = ena && !halted_q;
  assign tstate         = state_q;
  assign halted         = halted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= T1;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // Next state and control decode. The opcode is only looked at in T4..T6,
  // so instr may change freely during fetch without disturbing the outputs.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
`ifdef CTRL_JMP_EN
    pc_load  = 1'b0;
`endif
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_sub  = 1'b0;
    alu_out  = 1'b0;
    out_load = 1'b0;

    if (active) begin
      case (state_q)
        T1: begin
          state_d  = T2;
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: begin
          state_d = T3;
          pc_inc  = 1'b1;
        end
        T3: begin
          state_d = T4;
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          // HLT parks the ring on T4; only reset releases it.
          if (opcode == OP_HLT) begin
            halted_d = 1'b1;
          end else begin
            state_d = T5;
          end
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
`ifdef CTRL_JMP_EN
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
`endif
            OP_OUT: begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          state_d = T6;
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_load  = 1'b1;
            end
            OP_ADD: begin
              ram_out = 1'b1;
              b_load  = 1'b1;
            end
            OP_SUB: begin
              ram_out = 1'b1;
              b_load  = 1'b1;
              alu_sub = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          state_d = T1;
          case (opcode)
            OP_ADD: begin
              alu_out = 1'b1;
              a_load  = 1'b1;
            end
            OP_SUB: begin
              alu_out = 1'b1;
              a_load  = 1'b1;
              alu_sub = 1'b1;
            end
            default: ;
          endcase
        end
        // A corrupted (non-one-hot) ring drives nothing and restarts at T1.
        default: state_d = T1;
      endcase
    end
  end

endmodule

// File: tb/tb_controller_sequencer.sv
// tb/tb_controller_sequencer.sv - scoreboard bench for controller_sequencer

module tb_controller_sequencer;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] instr;
  logic       pc_out, pc_inc, pc_load_w, mar_load, ram_out, ir_load, ir_out;
  logic       a_load, a_out, b_load, alu_sub, alu_out, out_load;
  logic [5:0] tstate;
  logic       halted;

`ifdef CTRL_JMP_EN
  localparam bit JMP_EN = 1'b1;
  logic pc_load;
  assign pc_load_w = pc_load;
`else
  localparam bit JMP_EN = 1'b0;
  assign pc_load_w = 1'b0;
`endif

  controller_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .instr    (instr),
    .pc_out   (pc_out),
    .pc_inc   (pc_inc),
`ifdef CTRL_JMP_EN
    .pc_load  (pc_load),
`endif
    .mar_load (mar_load),
    .ram_out  (ram_out),
    .ir_load  (ir_load),
    .ir_out   (ir_out),
    .a_load   (a_load),
    .a_out    (a_out),
    .b_load   (b_load),
    .alu_sub  (alu_sub),
    .alu_out  (alu_out),
    .out_load (out_load),
    .tstate   (tstate),
    .halted   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [12:0] C_PC_OUT   = 13'h1000;
  localparam logic [12:0] C_PC_INC   = 13'h0800;
  localparam logic [12:0] C_PC_LOAD  = 13'h0400;
  localparam logic [12:0] C_MAR_LOAD = 13'h0200;
  localparam logic [12:0] C_RAM_OUT  = 13'h0100;
  localparam logic [12:0] C_IR_LOAD  = 13'h0080;
  localparam logic [12:0] C_IR_OUT   = 13'h0040;
  localparam logic [12:0] C_A_LOAD   = 13'h0020;
  localparam logic [12:0] C_A_OUT    = 13'h0010;
  localparam logic [12:0] C_B_LOAD   = 13'h0008;
  localparam logic [12:0] C_ALU_SUB  = 13'h0004;
  localparam logic [12:0] C_ALU_OUT  = 13'h0002;
  localparam logic [12:0] C_OUT_LOAD = 13'h0001;

  typedef struct {
    logic [5:0]  ts;
    logic        h;
    logic [12:0] ctrl;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   m_t      = 0;
  logic m_halt   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected controls for an enabled, non-halted cycle in step t (0 = T1).
  function automatic logic [12:0] exp_ctrl(input int t, input logic [3:0] op);
    logic [12:0] c;
    c = '0;
    case (t)
      0: c = C_PC_OUT | C_MAR_LOAD;
      1: c = C_PC_INC;
      2: c = C_RAM_OUT | C_IR_LOAD;
      3: begin
        if (op == 4'h0 || op == 4'h1 || op == 4'h2) c = C_IR_OUT | C_MAR_LOAD;
        else if (op == 4'h3 && JMP_EN)              c = C_IR_OUT | C_PC_LOAD;
        else if (op == 4'hE)                        c = C_A_OUT | C_OUT_LOAD;
      end
      4: begin
        if (op == 4'h0)      c = C_RAM_OUT | C_A_LOAD;
        else if (op == 4'h1) c = C_RAM_OUT | C_B_LOAD;
        else if (op == 4'h2) c = C_RAM_OUT | C_B_LOAD | C_ALU_SUB;
      end
      5: begin
        if (op == 4'h1)      c = C_ALU_OUT | C_A_LOAD;
        else if (op == 4'h2) c = C_ALU_OUT | C_A_LOAD | C_ALU_SUB;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // One cycle: apply inputs, queue the expected outputs, advance the model.
  task automatic cyc(input logic r, input logic e, input logic [7:0] i);
    exp_t x;
    @(posedge clk);
    #1;
    rst   = r;
    ena   = e;
    instr = i;
    x.ts   = 6'b000001 << m_t;
    x.h    = m_halt;
    x.ctrl = (e && !m_halt) ? exp_ctrl(m_t, i[7:4]) : 13'h0;
    sb_q.push_back(x);
    if (r) begin
      m_t    = 0;
      m_halt = 1'b0;
    end else if (e && !m_halt) begin
      if (m_t == 3 && i[7:4] == 4'hF) m_halt = 1'b1;
      else                            m_t    = (m_t + 1) % 6;
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [12:0] got;
      int drivers;
      e = sb_q.pop_front();
      got = {pc_out, pc_inc, pc_load_w, mar_load, ram_out, ir_load, ir_out,
             a_load, a_out, b_load, alu_sub, alu_out, out_load};
      drivers = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
      check("tstate", 32'(tstate), 32'(e.ts));
      check("halted", 32'(halted), 32'(e.h));
      check("ctrl", 32'(got), 32'(e.ctrl));
      check("bus_single_driver", 32'(drivers <= 1), 32'd1);
    end
  end

  initial begin
    rst   = 1'b1;
    ena   = 1'b0;
    instr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_tstate", 32'(tstate), 32'h01);
    check("reset_halted", 32'(halted), 32'h0);

    // Fetch/execute LDA twice around the ring
    cyc(1'b0, 1'b1, 8'h0A);
    for (int k = 0; k < 11; k++) cyc(1'b0, 1'b1, 8'h0A);
    // SUB, ADD, OUT, JMP/NOP, plain NOP
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'h2C);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'h15);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'hE0);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'h37);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'h70);
    // instr noise during fetch must not matter
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, (k < 3) ? 8'($urandom) : 8'h2A);
    // freeze at T3 for 4 clocks
    for (int k = 0; k < 2; k++) cyc(1'b0, 1'b1, 8'h0A);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b0, 8'h0A);
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 8'h0A);
    // HLT: park on T4 for 10+ clocks, then reset out of halt
    for (int k = 0; k < 4; k++)  cyc(1'b0, 1'b1, 8'hF0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 8'hF0);
    cyc(1'b1, 1'b0, 8'hF0);
    for (int k = 0; k < 6; k++)  cyc(1'b0, 1'b1, 8'h0A);
    // reset mid-instruction
    for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1, 8'h2C);
    cyc(1'b1, 1'b1, 8'h2C);
    for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, 8'h1C);
    // every opcode through every T-state
    for (int op = 0; op < 16; op++) begin
      for (int k = 0; k < 6; k++) cyc(1'b0, 1'b1, {4'(op), 4'h5});
      cyc(1'b1, 1'b1, {4'(op), 4'h5});
    end
    // random enable / instruction / rare reset
    for (int k = 0; k < 300; k++)
      cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/controller_sequencer.md
CONTROLLER_SEQUENCER -- requirements
Module: controller_sequencer

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 ena  input  1  step enable; low freezes sequencer.
REQ-004 instr  input  8  instruction register contents; bits [7:4] are the opcode.
REQ-005 pc_out  output  1  program counter drives bus.
REQ-006 pc_inc  output  1  program counter increments.
REQ-007 pc_load  output  1  program counter loads from bus (present only with CTRL_JMP_EN).
REQ-008 mar_load  output  1  memory address register loads from bus.
REQ-009 ram_out  output  1  RAM drives bus.
REQ-010 ir_load  output  1  instruction register loads from bus.
REQ-011 ir_out  output  1  IR operand nibble drives bus.
REQ-012 a_load  output  1  accumulator load strobe (to accumulator `load`).
REQ-013 a_out  output  1  accumulator bus drive (to accumulator `enable_output`).
REQ-014 b_load  output  1  B register loads from bus.
REQ-015 alu_sub  output  1  ALU subtract select.
REQ-016 alu_out  output  1  ALU drives bus.
REQ-017 out_load  output  1  output register loads from bus.
REQ-018 tstate  output  6  one-hot ring counter T1..T6 (bit0 = T1).
REQ-019 halted  output  1  high while halted.

Function
REQ-020 Ring counter SHALL advance T1->T2->...->T6->T1, one step per clock edge with ena=1 and halted=0.
REQ-021 With ena=0, tstate SHALL hold and all control outputs SHALL be 0.
REQ-022 Control outputs SHALL be combinational decode of tstate, instr[7:4], ena, halted; zero latency.
REQ-023 Fetch, all opcodes: T1 pc_out+mar_load; T2 pc_inc; T3 ram_out+ir_load.
REQ-024 LDA (0000): T4 ir_out+mar_load; T5 ram_out+a_load; T6 none.
REQ-025 ADD (0001): T4 ir_out+mar_load; T5 ram_out+b_load; T6 alu_out+a_load.
REQ-026 SUB (0010): as ADD, plus alu_sub high in T5 and T6.
REQ-027 OUT (1110): T4 a_out+out_load; T5, T6 none.
REQ-028 HLT (1111): in T4, halted SHALL set on that edge; tstate SHALL freeze at T4; all controls 0 until reset.
REQ-029 Any other opcode SHALL behave as NOP: T4..T6 no controls.
REQ-030 At most one of pc_out, ram_out, ir_out, a_out, alu_out SHALL be high in any cycle (single bus driver).
REQ-031 instr is sampled only in T4..T6; changes in T1..T3 SHALL not affect outputs.
REQ-032 Illegal non-one-hot tstate SHALL recover to T1 on next enabled edge.

Reset
REQ-033 rst=1 at an edge SHALL force tstate=6'b000001, halted=0, regardless of ena or current state, including mid-instruction and while halted.
REQ-034 After reset with ena=1: pc_out=1, mar_load=1, all other controls 0.

Configuration
REQ-035 Macro CTRL_JMP_EN defined: port pc_load exists; JMP (0011) SHALL assert ir_out+pc_load in T4, none in T5/T6.
REQ-036 CTRL_JMP_EN undefined: pc_load port absent; 0011 SHALL decode as NOP.

Verification
REQ-037 Reset then 6 enabled clocks with instr=8'h0A -> tstate 01,02,04,08,10,20,01; T4 ir_out+mar_load, T5 ram_out+a_load.
REQ-038 instr=8'h2C (SUB) -> T5 ram_out+b_load+alu_sub; T6 alu_out+a_load+alu_sub; T6 a_out=0.
REQ-039 instr=8'hE0 (OUT) -> T4 a_out=1, out_load=1, no other bus driver; T5/T6 all controls 0.
REQ-040 instr=8'hF0 reaching T4 -> halted=1, tstate=08 held 10 clocks, controls 0; rst=1 -> tstate=01, halted=0.
REQ-041 ena=0 at T3 for 4 clocks -> tstate stays 04, controls 0; ena=1 -> ir_load+ram_out, then T4.
REQ-042 Exhaustive all 16 opcodes x 6 T-states -> bus-driver one-hot-or-zero check; 0011 -> pc_load in T4 only with CTRL_JMP_EN, NOP without.
